vec_alu_pipe: RTL and testbench
===============================

# vec_alu_pipe

Parametrised, elastic SIMD integer ALU for the shader datapath: element-wise vector ops and full-width reductions (dot product, lane sum) over `NUM_LANES` lanes, with per-lane masking, a valid/ready handshake on both sides, and a transaction tag that travels with each operation. It sits between operand fetch and register writeback. It supersedes the fixed 4-lane, always-flowing ALU: it adds backpressure, masking, min/max/xor, and a reduction tree that scales with lane count.

## Interface
Parameters:
- `LANE_WIDTH`, 32: bits per lane; must be at least 8.
- `NUM_LANES`, 8: lane count; a power of two, at least 2.
- `TAG_WIDTH`, 4: width of the opaque tag carried with each operation.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: the input operation is valid.
- `in_ready`, out, 1: the ALU accepts the input this cycle.
- `in_op`, in, 5: opcode.
- `in_mask`, in, NUM_LANES: per-lane enable; bit i corresponds to lane i.
- `in_tag`, in, TAG_WIDTH: tag, returned unchanged on the output.
- `vec_a`, in, NUM_LANES*LANE_WIDTH: operand A; lane i is bits [(i+1)*LANE_WIDTH-1 -: LANE_WIDTH].
- `vec_b`, in, NUM_LANES*LANE_WIDTH: operand B, same lane packing as A.
- `out_valid`, out, 1: the output is valid.
- `out_ready`, in, 1: the consumer accepts the output.
- `out_vec`, out, NUM_LANES*LANE_WIDTH: vector result.
- `out_scalar`, out, LANE_WIDTH: reduction result.
- `out_tag`, out, TAG_WIDTH: the tag of the output operation.
- `out_illegal`, out, 1: the operation carried an unsupported opcode.

## Operation
Opcodes:
- `V_ADD` 00001, `V_SUB` 00010: a±b per lane.
- `V_MUL` 00011: a*b per lane, keeping the low LANE_WIDTH bits.
- `V_AND` 00100, `V_OR` 00101, `V_XOR` 00110: bitwise per lane.
- `V_MIN` 00111, `V_MAX` 01000: per lane, both operands treated as signed.
- `DOTN` 10001: sum over enabled lanes of a*b.
- `RSUM` 10011: sum over enabled lanes of a.

Result rules:
- All arithmetic wraps modulo 2^LANE_WIDTH. There is no saturation and no carry out.
- A masked-off lane produces 0 in `out_vec` and contributes 0 to any reduction.
- For vector ops, `out_scalar` is 0.
- For reductions, `out_vec` is 0.
- Any other opcode, including the retired `RSQRT` 10010:
  - still flows through the pipe and is handshaken normally;
  - `out_vec` and `out_scalar` are 0;
  - `out_illegal` is 1.
- When all mask bits are 0, the result is all zeros with `out_valid` still asserted. A vector op outputs 0 in every lane; a reduction outputs `out_scalar` = 0.
- `out_tag` always equals the `in_tag` of the same transaction.
- Results come out in the order the inputs were accepted.

## Timing
Pipeline shape:
- Latency `LAT` = 2 + log2(NUM_LANES) cycles, from the acceptance edge to `out_valid`. This is 5 for the default of 8 lanes.
- Stage 1 is the input register.
- Stage 2 is lane execute, which also forms the products and masked terms used by the reductions.
- Stages 3 to LAT are the registered levels of the adder tree, one level per stage. Vector results ride alongside the tree unchanged.

Handshake:
- A stage holds a valid bit plus its payload.
- The global advance is `adv = !out_valid || out_ready`. When `adv` is 1, every stage moves one step at once; when it is 0, the whole pipe holds.
- `in_ready = adv`. This is a combinational path from `out_ready`, and it is permitted.
- A transfer happens when `in_valid && in_ready`; otherwise a bubble, with valid = 0, enters stage 1.
- A transaction leaves when `out_valid && out_ready`.
- While `out_valid=1 && out_ready=0`, all outputs hold stable.
- With `out_ready` held at 1, throughput is one operation per cycle.
- Bubbles are not squeezed out: a stall freezes them in place.

Reset:
- On a `clk` edge with `rst` high, every stage valid bit clears, and `out_valid`, `out_vec`, `out_scalar`, `out_tag` and `out_illegal` all become 0.
- Any operations in flight are discarded without producing output.
- `in_ready` reads 1 in the cycle following reset.
- No input is accepted on an edge where `rst` is high.

## Structure
- Package `vec_alu_pkg` holds:
  - the opcode localparams (the `op_e` enum);
  - a function `alu_lat(num_lanes)` that returns 2 + $clog2(num_lanes);
  - the lane-extraction helper.
- Sub-module `vec_alu_lane`: one lane's combinational element-wise operation. It takes the opcode, a, b and the mask bit, and produces the vector result and the reduction term (a*b, or a, or 0).
- The top level instantiates NUM_LANES lanes with `generate`, builds the registered adder tree with a level loop, and implements the stall-able valid chain.
- Latency is checked against `alu_lat` with an elaboration-time assertion.

## Test plan
All scenarios use LANE_WIDTH=32, NUM_LANES=8, and `out_ready`=1 unless stated.
- **V_ADD wrap and mask.** a lanes = 0xFFFFFFFF, b lanes = 2, mask = 0x0F → lanes 0–3 = 1, lanes 4–7 = 0, scalar 0, output 5 cycles after acceptance.
- **DOTN.** a = {1..8}, b = {8..1}, mask = 0xFF → out_scalar = 120, out_vec = 0. The same inputs with mask = 0x81 → 16.
- **Signed min, plus RSUM.**
  - V_MIN with a = 0xFFFFFFFF (−1) and b = 5 → 0xFFFFFFFF in every lane.
  - RSUM with a = {10,20,…,80} and mask = 0xFF → 360.
- **Backpressure.** Issue 8 back-to-back ops with tags 0–7, and hold `out_ready`=0 from cycle 6 to cycle 10 → `in_ready`=0 during the stall, outputs stable, all 8 delivered in tag order with none lost or duplicated.
- **Illegal opcode.** op = 10010 with tag 0xA → `out_illegal`=1, results 0, `out_tag`=0xA, handshake completes normally.
- **Mid-stream reset.** Assert `rst` for 1 cycle while 3 ops are in flight → no `out_valid` for those ops; a new op issued right after reset returns exactly 5 cycles later.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: opcodes and helpers shared by the SIMD ALU pipeline
package vec_alu_pkg;
  typedef enum logic [4:0] {
    V_ADD = 5'b00001,
    V_SUB = 5'b00010,
    V_MUL = 5'b00011,
    V_AND = 5'b00100,
    V_OR  = 5'b00101,
    V_XOR = 5'b00110,
    V_MIN = 5'b00111,
    V_MAX = 5'b01000,
    DOTN  = 5'b10001,
    RSUM  = 5'b10011
  } op_e;

  function automatic int alu_lat(int num_lanes);
    return 2 + $clog2(num_lanes);
  endfunction

  function automatic int lane_lo(int lane, int width);
    return lane * width;
  endfunction

  function automatic logic op_legal(logic [4:0] op);
    return (op >= V_ADD && op <= V_MAX) || op == DOTN || op == RSUM;
  endfunction
endpackage

// File: rtl/vec_alu_lane.sv
// vec_alu_lane: one lane's element-wise result and reduction term
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int LANE_WIDTH = 32
) (
  input  logic [4:0]            op,
  input  logic                  en,
  input  logic [LANE_WIDTH-1:0] a,
  input  logic [LANE_WIDTH-1:0] b,
  output logic [LANE_WIDTH-1:0] res,
  output logic [LANE_WIDTH-1:0] term
);
  logic [LANE_WIDTH-1:0] prod;
  logic                  lt;

  always_comb begin
    prod = a * b;
    lt   = $signed(a) < $signed(b);
    res  = '0;
    term = '0;
    if (en)
      case (op)
        V_ADD:   res = a + b;
        V_SUB:   res = a - b;
        V_MUL:   res = prod;
        V_AND:   res = a & b;
        V_OR:    res = a | b;
        V_XOR:   res = a ^ b;
        V_MIN:   res = lt ? a : b;
        V_MAX:   res = lt ? b : a;
        DOTN:    term = prod;
        RSUM:    term = a;
        default: res = '0;
      endcase
  end
endmodule

// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: elastic masked SIMD ALU with a registered reduction tree
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int LANE_WIDTH = 32,
  parameter int NUM_LANES  = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [4:0]                      in_op,
  input  logic [NUM_LANES-1:0]            in_mask,
  input  logic [TAG_WIDTH-1:0]            in_tag,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] vec_a,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] vec_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_vec,
  output logic [LANE_WIDTH-1:0]           out_scalar,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic                            out_illegal
);
  localparam int LW   = LANE_WIDTH;
  localparam int N    = NUM_LANES;
  localparam int LVLS = $clog2(N);
  localparam int LAT  = 2 + LVLS;
  localparam int VW   = N * LW;

  if (LAT != alu_lat(NUM_LANES) || (1 << LVLS) != N || N < 2 || LW < 8) begin : g_bad
    $error("vec_alu_pipe: unsupported parameters or latency mismatch");
  end

  logic                 adv;
  logic [LAT:1]         v;
  logic [TAG_WIDTH-1:0] tag_p [1:LAT];
  logic [4:0]           op1;
  logic [N-1:0]         mask1;
  logic [VW-1:0]        a1, b1;
  logic [VW-1:0]        vec_p [2:LAT];
  logic [LAT:2]         ill_p;
  logic [VW-1:0]        lane_res;
  logic [LW-1:0]        lane_term [N];
  // Heap-ordered adder tree: leaves N..2N-1 are lane terms, node 1 is the root.
  logic [LW-1:0]        t [1:2*N-1];

  for (genvar i = 0; i < N; i++) begin : g_lane
    vec_alu_lane #(.LANE_WIDTH(LW)) u_lane (
      .op  (op1),
      .en  (mask1[i]),
      .a   (a1[lane_lo(i, LW) +: LW]),
      .b   (b1[lane_lo(i, LW) +: LW]),
      .res (lane_res[lane_lo(i, LW) +: LW]),
      .term(lane_term[i])
    );
  end

  assign adv      = !v[LAT] || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      op1   <= '0;
      mask1 <= '0;
      a1    <= '0;
      b1    <= '0;
      ill_p <= '0;
      for (int s = 1; s <= LAT; s++) tag_p[s] <= '0;
      for (int s = 2; s <= LAT; s++) vec_p[s] <= '0;
      for (int i = 1; i < 2 * N; i++) t[i] <= '0;
    end else if (adv) begin
      v        <= {v[LAT-1:1], in_valid};
      tag_p[1] <= in_tag;
      op1      <= in_op;
      mask1    <= in_mask;
      a1       <= vec_a;
      b1       <= vec_b;
      tag_p[2] <= tag_p[1];
      vec_p[2] <= lane_res;
      ill_p[2] <= !op_legal(op1);
      for (int s = 3; s <= LAT; s++) begin
        tag_p[s] <= tag_p[s-1];
        vec_p[s] <= vec_p[s-1];
        ill_p[s] <= ill_p[s-1];
      end
      for (int i = 0; i < N; i++) t[N+i] <= lane_term[i];
      for (int i = 1; i < N; i++) t[i] <= t[2*i] + t[2*i+1];
    end
  end

  assign out_valid   = v[LAT];
  assign out_vec     = vec_p[LAT];
  assign out_scalar  = t[1];
  assign out_tag     = tag_p[LAT];
  assign out_illegal = ill_p[LAT];
endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb_vec_alu_pipe: directed scoreboard bench for vec_alu_pipe
module tb_vec_alu_pipe;
  localparam int LW = 32, N = 8, TW = 4, LAT = 5, VW = N * LW;
  localparam logic [4:0] OP_ADD = 5'b00001, OP_SUB = 5'b00010, OP_MUL = 5'b00011,
                         OP_AND = 5'b00100, OP_OR = 5'b00101, OP_XOR = 5'b00110,
                         OP_MIN = 5'b00111, OP_MAX = 5'b01000, OP_DOT = 5'b10001,
                         OP_RSQ = 5'b10010, OP_RSUM = 5'b10011;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_illegal;
  logic [4:0] in_op = '0;
  logic [N-1:0] in_mask = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic [VW-1:0] vec_a = '0, vec_b = '0, out_vec;
  logic [LW-1:0] out_scalar;

  typedef struct {
    logic [TW-1:0] tag;
    logic [VW-1:0] vec;
    logic [LW-1:0] sc;
    logic          ill;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int checks = 0, passes = 0, cyc = 0;
  bit acc = 0, hold = 0;
  logic [VW-1:0] h_vec;
  logic [LW-1:0] h_sc;
  logic [TW-1:0] h_tag;

  vec_alu_pipe #(.LANE_WIDTH(LW), .NUM_LANES(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_mask(in_mask), .in_tag(in_tag), .vec_a(vec_a), .vec_b(vec_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_scalar(out_scalar), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [VW-1:0] obs, logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  function automatic exp_t mk(logic [TW-1:0] tag, logic [VW-1:0] v, logic [LW-1:0] s,
                              logic ill, bit lat);
    exp_t e;
    e.tag = tag; e.vec = v; e.sc = s; e.ill = ill; e.cyc = 0; e.lat = lat;
    return e;
  endfunction

  function automatic exp_t model(logic [4:0] op, logic [N-1:0] m, logic [VW-1:0] a,
                                 logic [VW-1:0] b, logic [TW-1:0] tag);
    exp_t e;
    logic [LW-1:0] x, y, r;
    e = mk(tag, '0, '0, 1'b0, 1'b0);
    e.ill = !(op inside {[5'd1:5'd8], 5'd17, 5'd19});
    for (int i = 0; i < N; i++) begin
      x = a[i*LW +: LW];
      y = b[i*LW +: LW];
      r = '0;
      if (m[i] && !e.ill)
        case (op)
          OP_ADD:  r = x + y;
          OP_SUB:  r = x - y;
          OP_MUL:  r = x * y;
          OP_AND:  r = x & y;
          OP_OR:   r = x | y;
          OP_XOR:  r = x ^ y;
          OP_MIN:  r = ($signed(x) < $signed(y)) ? x : y;
          OP_MAX:  r = ($signed(x) > $signed(y)) ? x : y;
          OP_DOT:  e.sc = e.sc + x * y;
          OP_RSUM: e.sc = e.sc + x;
          default: r = '0;
        endcase
      e.vec[i*LW +: LW] = r;
    end
    return e;
  endfunction

  function automatic logic [VW-1:0] rnd();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*LW +: LW] = $urandom;
    return r;
  endfunction

  // One cycle: sample at negedge, score outputs, record acceptance, return just after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (hold) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_vec", out_vec, h_vec);
      chk("stall_scalar", out_scalar, h_sc);
      chk("stall_tag", out_tag, h_tag);
    end
    hold  = !rst && out_valid && !out_ready;
    h_vec = out_vec; h_sc = out_scalar; h_tag = out_tag;
    if (hold) chk("in_ready_stall", in_ready, 0);
    if (out_valid && out_ready) begin
      chk("expected_output", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tag", out_tag, e.tag);
        chk("vec", out_vec, e.vec);
        chk("scalar", out_scalar, e.sc);
        chk("illegal", out_illegal, e.ill);
        if (e.lat) chk("latency", cyc - e.cyc, LAT);
      end
    end
    acc = 0;
    if (rst) sb.delete();
    else if (in_valid && in_ready) begin
      e = nxt;
      e.cyc = cyc;
      sb.push_back(e);
      acc = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [4:0] op, logic [N-1:0] m, logic [VW-1:0] a, logic [VW-1:0] b,
                       exp_t e);
    in_valid = 1; in_op = op; in_mask = m; vec_a = a; vec_b = b; in_tag = e.tag;
    nxt = e;
    acc = 0;
    for (int k = 0; k < 40 && !acc; k++) tick();
    in_valid = 0;
    chk("accepted", acc, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
    chk("drained", sb.size(), 0);
  endtask

  logic [VW-1:0] da, db, ra, rb;
  logic [N-1:0] rm;
  logic [4:0] bp_ops [8];
  int sent;

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_scalar", out_scalar, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_illegal", out_illegal, 0);

    issue(OP_ADD, 8'h0F, {8{32'hFFFF_FFFF}}, {8{32'h2}},
          mk(4'h1, {128'h0, {4{32'h1}}}, '0, 1'b0, 1'b1));
    drain();

    for (int i = 0; i < N; i++) begin
      da[i*LW +: LW] = 32'(i + 1);
      db[i*LW +: LW] = 32'(8 - i);
    end
    issue(OP_DOT, 8'hFF, da, db, mk(4'h2, '0, 32'd120, 1'b0, 1'b0));
    issue(OP_DOT, 8'h81, da, db, mk(4'h3, '0, 32'd16, 1'b0, 1'b0));
    issue(OP_MIN, 8'hFF, {8{32'hFFFF_FFFF}}, {8{32'd5}},
          mk(4'h4, {8{32'hFFFF_FFFF}}, '0, 1'b0, 1'b0));
    issue(OP_MAX, 8'hFF, {8{32'hFFFF_FFFF}}, {8{32'd5}}, mk(4'h5, {8{32'd5}}, '0, 1'b0, 1'b0));
    for (int i = 0; i < N; i++) da[i*LW +: LW] = 32'(10 * (i + 1));
    issue(OP_RSUM, 8'hFF, da, db, mk(4'h6, '0, 32'd360, 1'b0, 1'b0));
    issue(OP_ADD, 8'h00, da, db, mk(4'h7, '0, '0, 1'b0, 1'b0));
    issue(OP_RSUM, 8'h00, da, db, mk(4'h8, '0, '0, 1'b0, 1'b0));
    issue(OP_RSQ, 8'hFF, da, db, mk(4'hA, '0, '0, 1'b1, 1'b0));
    issue(5'b00000, 8'hFF, da, db, mk(4'hB, '0, '0, 1'b1, 1'b0));
    drain();

    bp_ops = '{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_MAX, OP_DOT};
    sent = 0;
    ra = rnd(); rb = rnd(); rm = N'($urandom);
    for (int k = 0; k < 80 && (sent < 8 || sb.size() > 0); k++) begin
      out_ready = !(k >= 6 && k <= 10);
      in_valid = sent < 8;
      if (sent < 8) begin
        in_op = bp_ops[sent]; in_mask = rm; vec_a = ra; vec_b = rb; in_tag = TW'(sent);
        nxt = model(bp_ops[sent], rm, ra, rb, TW'(sent));
      end
      tick();
      if (acc) begin
        sent++;
        ra = rnd(); rb = rnd(); rm = N'($urandom);
      end
    end
    in_valid = 0;
    out_ready = 1;
    chk("bp_sent", sent, 8);
    chk("bp_drained", sb.size(), 0);

    for (int i = 1; i <= 3; i++) begin
      ra = rnd(); rb = rnd();
      issue(OP_ADD, 8'hFF, ra, rb, model(OP_ADD, 8'hFF, ra, rb, TW'(i)));
    end
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_vec", out_vec, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    issue(OP_SUB, 8'hFF, {8{32'd9}}, {8{32'd4}}, mk(4'h9, {8{32'd5}}, '0, 1'b0, 1'b1));
    drain();
    for (int k = 0; k < 8; k++) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
